// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver on a 16x oversample tick: two-flop synchroniser, start-edge
// search on the tick grid, mid-bit sampling, stop-bit check and a one-clock rx_done strobe.
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic [1:0]           dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_done_q, rx_done_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   sync1_q, sync2_q;
  logic                   rx_s;

  // Sync flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      rx_busy_q   <= rx_busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    frame_err_d = frame_err_q;
    rx_done_d   = 1'b0;

    // Without a tick nothing advances; this is what freezes a frame when ticks stop.
    if (b_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            rx_data_d   = shift_q;
            frame_err_d = ~rx_s;
            rx_done_d   = 1'b1;
            state_d     = S_IDLE;
            tick_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end

    rx_busy_d = (state_d != S_IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: tick-timed serial driver, expected-frame queue and a monitor
// that checks every rx_done strobe against the queue head.
module tb_uart_rx_os16;

  // rx_done handshake: each rx_done=1 cycle is one delivered frame; rx_data and
  // frame_err are sampled in that same cycle and matched to the oldest queued frame.

  logic       clk = 1'b0;
  logic       rst;
  logic       b_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];        // {frame_err, data}
  logic [7:0] last_data = 8'h00;
  logic       tick_en = 1'b0;
  int         tick_num = 0;
  int         div = 0;
  logic       prev_done = 1'b0;

  uart_rx_os16 #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / tick generation ----------------
  always #5 clk = ~clk;

  initial begin
    b_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      b_tick = tick_en && (div == 0);
      if (b_tick) tick_num++;
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    int target;
    int cyc;
    target = tick_num + n;
    cyc = 0;
    while (tick_num < target && cyc < n * 4 + 1200) begin
      @(negedge clk);
      cyc++;
    end
    if (tick_num < target) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: got %0d ticks expected %0d", tick_num, target);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(16);
    rx = 1'b1;
  endtask

  task automatic push_and_send(input logic [7:0] data, input logic stop);
    exp_q.push_back({~stop, data});
    last_data = data;
    send_frame(data, stop);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (rx_done && prev_done) check("rx_done_double", 1, 0);
      if (rx_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rx_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'h0, rx_data}, {24'h0, e[7:0]});
          check("frame_err", {31'h0, frame_err}, {31'h0, e[8]});
        end
      end
      prev_done = rx_done;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_rx_done", {31'h0, rx_done}, 32'h0);
    check("rst_rx_busy", {31'h0, rx_busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    rst = 1'b0;
    tick_en = 1'b1;
    wait_ticks(20);

    // 1: single good frame
    push_and_send(8'h55, 1'b1);
    wait_ticks(4);
    check("t1_busy_after", {31'h0, rx_busy}, 32'h0);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: back-to-back frames
    push_and_send(8'hA3, 1'b1);
    push_and_send(8'h00, 1'b1);
    wait_ticks(20);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: short glitch is rejected
    rx = 1'b0;
    wait_ticks(3);
    check("t3_busy_rise", {31'h0, rx_busy}, 32'h1);
    wait_ticks(1);
    rx = 1'b1;
    cyc = 0;
    while (rx_busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_busy_fall", {31'h0, rx_busy}, 32'h0);
    wait_ticks(20);
    check("t3_rx_data_held", {24'h0, rx_data}, {24'h0, last_data});
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: framing error then recovery
    push_and_send(8'hFF, 1'b0);
    wait_ticks(20);
    check("t4_busy_idle", {31'h0, rx_busy}, 32'h0);
    push_and_send(8'h12, 1'b1);
    wait_ticks(20);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: reset mid-frame (0xC3, LSB first bits 1,1,0 sent)
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b0; wait_ticks(16);
    rx = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_data = 8'h00;
    check("t5_rx_data", {24'h0, rx_data}, 32'h0);
    check("t5_rx_done", {31'h0, rx_done}, 32'h0);
    check("t5_rx_busy", {31'h0, rx_busy}, 32'h0);
    check("t5_frame_err", {31'h0, frame_err}, 32'h0);
    check("t5_state", {30'h0, dbg_state}, 32'h0);
    wait_ticks(40);
    check("t5_no_done", exp_q.size(), 0);
    push_and_send(8'h3C, 1'b1);
    wait_ticks(20);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: ticks frozen mid-frame
    fork
      push_and_send(8'h96, 1'b1);
      begin
        wait_ticks(16 * 4 + 6);
        tick_en = 1'b0;
        repeat (1000) @(negedge clk);
        check("t6_state_frozen", {30'h0, dbg_state}, 32'h2);
        check("t6_busy_frozen", {31'h0, rx_busy}, 32'h1);
        check("t6_done_frozen", exp_q.size(), 1);
        tick_en = 1'b1;
      end
    join
    wait_ticks(20);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_busy_after", {31'h0, rx_busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
